trap_addr_fifo: RTL
===================

// Module: trap_addr_fifo
// PURPOSE
//  Captures the Z80 address and direction of each mapper I/O violation when the
//  mapping logic asserts trap_addr_wr_n, and queues them in a small FIFO.
//  The trap handler reads each queued address back through the mapper I/O window
//  as low byte then high byte. Reading the high byte pops the entry.
//  Sits downstream of the mapping/trap glue. Consumes its trap_addr_wr_n/trap_addr_rd_n
//  strobes and drives the data bus during trap-address reads.
// PARAMETERS
//  DEPTH_LOG2   2   log2 of FIFO depth (default 4 entries)
//  SYNC_STAGES  2   synchroniser flops per async strobe (>=2)
// PORTS
//  clk             in   1   CPLD clock; must be >= 4x Z80 clock
//  reset           in   1   synchronous, active-high reset
//  addr            in   16  Z80 address bus (async; stable for whole I/O cycle)
//  io_dir          in   1   direction of trapped I/O (1 = OUT, 0 = IN)
//  trap_addr_wr_n  in   1   async, active-low: I/O violation in progress
//  trap_addr_rd_n  in   1   async, active-low: CPU reading trap address
//  byte_sel        in   1   lo_addr[0]: 0 = low byte, 1 = high byte
//  ovf_clr         in   1   synchronous pulse: clear overflow flag
//  data_out        out  8   read data for the Z80 bus
//  data_oe         out  1   data_out drive enable
//  trap_pending    out  1   FIFO non-empty
//  trap_overflow   out  1   sticky flag: a violation was dropped
//  head_dir        out  1   io_dir of the head entry (0 when empty)
// BEHAVIOUR
//  - Reset: FIFO empty (rd_ptr = wr_ptr = count = 0); trap_overflow = 0; head_dir = 0.
//    Synchroniser chains are set to the asserted (0) level. A strobe that is held
//    low across reset release is therefore ignored until it deasserts.
//  - Strobes: each strobe passes through SYNC_STAGES flops, then one edge-detect flop.
//    A wr event is the synchronised 1->0 edge of trap_addr_wr_n.
//    A pop event is the synchronised 0->1 edge of trap_addr_rd_n, but only when byte_sel
//    was 1, sampled on that same clk.
//  - Push: on the clk where the wr event is detected, {io_dir, addr} is written to
//    mem[wr_ptr] and wr_ptr is incremented. Latency from strobe to trap_pending is
//    SYNC_STAGES+1 clks.
//  - Full push: the entry is dropped, trap_overflow is set to 1, and the pointers are unchanged.
//  - Pop on empty: ignored; no pointer change, no flag change.
//  - Simultaneous push and pop:
//    - Both are applied and count is unchanged.
//    - When full, no overflow is flagged.
//    - When empty, the push alone is applied.
//  - Pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2.
//    count is DEPTH_LOG2+1 bits, with full when count == 2^DEPTH_LOG2.
//  - ovf_clr: clears trap_overflow on the next clk. If ovf_clr and an overflowing
//    push occur on the same clk, the set wins.
//  - Read path:
//    - data_oe = !trap_addr_rd_n (combinational, unsynchronised).
//    - data_out = byte_sel ? head[15:8] : head[7:0].
//    - When empty, data_out = 8'hFF.
//    - The head changes only after the rd strobe deasserts, so data is stable
//      for the whole read.
//  - trap_pending = (count != 0), registered. head_dir = mem[rd_ptr][16] when
//    non-empty, else 0.
//  - No state machine beyond the FIFO. The byte order is software-defined
//    (low byte, then high byte). A low-byte read alone never pops.
// TESTING
//  1. Reset, then one wr pulse with addr=16'h12A5, io_dir=1 -> after 3 clks
//     trap_pending=1 and head_dir=1; rd with byte_sel=0 gives A5; rd with byte_sel=1
//     gives 12; after the high read deasserts, trap_pending=0.
//  2. Push 5 violations (addrs 0x0100..0x0104) with DEPTH_LOG2=2 -> trap_overflow=1;
//     4 high-byte reads return 01,01,01,01 with low bytes 00..03; 0x0104 is lost.
//  3. Read while empty -> data_out=FF, data_oe=1, no pointer change, trap_pending stays 0.
//  4. FIFO full, wr and high-byte read edges detected on the same clk -> count stays 4,
//     trap_overflow stays 0, new entry at tail.
//  5. ovf_clr pulse with trap_overflow=1 -> 0 next clk; ovf_clr coincident with a
//     full push -> remains 1.
//  6. reset asserted mid-read with trap_addr_wr_n held low through release -> no
//     push until the strobe rises and falls again; FIFO empty, flags 0.

Source files
------------

// File: rtl/trap_addr_fifo_if.sv
// rtl/trap_addr_fifo_if.sv - Z80-side bus bundle for the trap address FIFO
interface trap_addr_fifo_if;
   logic [15:0] addr;
   logic        io_dir;
   logic        trap_addr_wr_n;
   logic        trap_addr_rd_n;
   logic        byte_sel;
   logic [7:0]  data_out;
   logic        data_oe;

   modport master (
      output addr,
      output io_dir,
      output trap_addr_wr_n,
      output trap_addr_rd_n,
      output byte_sel,
      input  data_out,
      input  data_oe
   );

   modport slave (
      input  addr,
      input  io_dir,
      input  trap_addr_wr_n,
      input  trap_addr_rd_n,
      input  byte_sel,
      output data_out,
      output data_oe
   );
endinterface

// File: rtl/trap_addr_fifo.sv
// rtl/trap_addr_fifo.sv - queue of trapped Z80 I/O addresses read back low byte then high byte
module trap_addr_fifo #(
   parameter int DEPTH_LOG2  = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   trap_addr_fifo_if.slave  bus,
   input  logic             ovf_clr,
   output logic             trap_pending,
   output logic             trap_overflow,
   output logic             head_dir
);

   localparam int                  DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] COUNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] COUNT_ONE = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [16:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   rd_ptr;
   logic [DEPTH_LOG2:0]     count;

   logic [SYNC_STAGES-1:0]  wr_sync;
   logic [SYNC_STAGES-1:0]  rd_sync;
   logic                    wr_prev;
   logic                    rd_prev;
   logic                    wr_level;
   logic                    rd_level;

   logic                    wr_evt;
   logic                    pop_evt;
   logic                    empty;
   logic                    full;
   logic                    do_push;
   logic                    do_pop;
   logic                    ovf_set;
   logic [16:0]             head;

   // Chains reset to the asserted level so a strobe held low across reset
   // release produces no edge until it has gone high and come back down.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_sync <= '0;
         rd_sync <= '0;
         wr_prev <= 1'b0;
         rd_prev <= 1'b0;
      end else begin
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], bus.trap_addr_wr_n};
         rd_sync <= {rd_sync[SYNC_STAGES-2:0], bus.trap_addr_rd_n};
         wr_prev <= wr_level;
         rd_prev <= rd_level;
      end
   end

   assign wr_level = wr_sync[SYNC_STAGES-1];
   assign rd_level = rd_sync[SYNC_STAGES-1];

   assign wr_evt  = wr_prev && !wr_level;
   assign pop_evt = !rd_prev && rd_level && bus.byte_sel;

   assign empty   = (count == '0);
   assign full    = (count == COUNT_MAX);

   // A pop on empty is dropped; a pop frees a slot for a push on the same clk.
   assign do_pop  = pop_evt && !empty;
   assign do_push = wr_evt && (!full || do_pop);
   assign ovf_set = wr_evt && full && !do_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (do_push && !do_pop) begin
            count <= count + COUNT_ONE;
         end else if (do_pop && !do_push) begin
            count <= count - COUNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= {bus.io_dir, bus.addr};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         trap_overflow <= 1'b0;
      end else if (ovf_set) begin
         trap_overflow <= 1'b1;
      end else if (ovf_clr) begin
         trap_overflow <= 1'b0;
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      bus.data_out = 8'hFF;
      head_dir     = 1'b0;
      if (!empty) begin
         bus.data_out = bus.byte_sel ? head[15:8] : head[7:0];
         head_dir     = head[16];
      end
   end

   assign bus.data_oe  = !bus.trap_addr_rd_n;
   assign trap_pending = !empty;

endmodule
